keypad_scan_ctrl: RTL and testbench

Scan controller for the 3x4 matrix keypad on the sound-keypad board. Drives the four row lines one-hot in rotation and samples the three column lines through a synchronizer. It debounces a single pressed key by repeated matching samples, then reports a 4-bit key code with a one-cycle valid pulse. It sequences the keypad for the tone generator and seven-segment logic and replaces direct, unscanned use of the column lines.

---
 rtl/keypad_scan_ctrl_if.sv | 10 +
 rtl/keypad_scan_ctrl.sv | 108 ++++++++++
 tb/tb_keypad_scan_ctrl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/keypad_scan_ctrl_if.sv
// keypad_scan_ctrl_if: keypad bundle; rows A-D out, columns E-G in, key_code/key_valid/key_held report out (master = scanner)
interface keypad_scan_ctrl_if;
  logic       E, F, G;
  logic       A, B, C, D;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  modport master (input E, F, G, output A, B, C, D, key_code, key_valid, key_held);
  modport slave (output E, F, G, input A, B, C, D, key_code, key_valid, key_held);
endinterface

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 3x4 keypad row scanner with debounce; ports sys_clk, sys_rst, kp (rows A-D out, cols E-G in, key_code/key_valid/key_held out)
module keypad_scan_ctrl #(
  parameter int SCAN_DIV     = 16,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  keypad_scan_ctrl_if.master kp
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);
  typedef enum logic [1:0] {SCAN, CONFIRM, HOLD} state_t;
  state_t        state_q, state_d;
  logic [2:0]    s1_q, s2_q;
  logic [DW-1:0] dwell_q;
  logic [3:0]    row_q, row_d, row_nx;
  logic [1:0]    cand_row_q, cand_row_d, ri, ci;
  logic [2:0]    cand_col_q, cand_col_d;
  logic [CW-1:0] cnt_q, cnt_d, rel_q, rel_d;
  logic [3:0]    code_q, code_d;
  logic          valid_q, valid_d, held_q, held_d;
  logic          samp, one_hot;
  assign samp    = dwell_q == DW'(SCAN_DIV - 1);
  assign one_hot = s2_q inside {3'b001, 3'b010, 3'b100};
  assign row_nx  = {row_q[2:0], row_q[3]};
  assign ri      = row_q[3] ? 2'd3 : row_q[2] ? 2'd2 : row_q[1] ? 2'd1 : 2'd0;
  assign ci      = cand_col_q[2] ? 2'd2 : cand_col_q[1] ? 2'd1 : 2'd0;
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    cand_row_d = cand_row_q;
    cand_col_d = cand_col_q;
    cnt_d      = cnt_q;
    rel_d      = rel_q;
    code_d     = code_q;
    valid_d    = 1'b0;
    held_d     = held_q;
    if (samp)
      case (state_q)
        SCAN:
          if (one_hot) begin
            cand_row_d = ri;
            cand_col_d = s2_q;
            cnt_d      = CW'(1);
            state_d    = CONFIRM;
          end else
            row_d = row_nx;
        CONFIRM:
          if (s2_q == cand_col_q) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == CW'(DEBOUNCE_CNT)) begin
              code_d  = {2'b00, cand_row_q} * 4'd3 + {2'b00, ci};
              valid_d = 1'b1;
              held_d  = 1'b1;
              rel_d   = '0;
              cnt_d   = '0;
              state_d = HOLD;
            end
          end else begin
            cnt_d   = '0;
            row_d   = row_nx;
            state_d = SCAN;
          end
        HOLD: begin
          rel_d = s2_q == 3'b000 ? rel_q + 1'b1 : '0;
          if (rel_d == CW'(DEBOUNCE_CNT)) begin
            rel_d   = '0;
            held_d  = 1'b0;
            row_d   = row_nx;
            state_d = SCAN;
          end
        end
        default: state_d = SCAN;
      endcase
  end
  always_ff @(posedge sys_clk)
    if (sys_rst) begin
      state_q    <= SCAN;
      s1_q       <= '0;
      s2_q       <= '0;
      dwell_q    <= '0;
      row_q      <= 4'b0001;
      cand_row_q <= '0;
      cand_col_q <= '0;
      cnt_q      <= '0;
      rel_q      <= '0;
      code_q     <= '0;
      valid_q    <= 1'b0;
      held_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      s1_q       <= {kp.G, kp.F, kp.E};
      s2_q       <= s1_q;
      dwell_q    <= samp ? '0 : dwell_q + 1'b1;
      row_q      <= row_d;
      cand_row_q <= cand_row_d;
      cand_col_q <= cand_col_d;
      cnt_q      <= cnt_d;
      rel_q      <= rel_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      held_q     <= held_d;
    end
  assign {kp.D, kp.C, kp.B, kp.A} = row_q;
  assign kp.key_code  = code_q;
  assign kp.key_valid = valid_q;
  assign kp.key_held  = held_q;
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl: randomized keypad scenarios checked against a sample-level behavioural model
module tb_keypad_scan_ctrl;
  localparam int SD = 4;
  localparam int DB = 3;
  logic       clk, rst;
  bit         key_on, chk_en;
  int         key_row;
  logic [2:0] key_cols;
  int         n_cmp, n_bad, n_valid, last_code;
  logic [3:0] rows, rows_seen;
  logic [2:0] m_s1, m_s2;
  int         m_ph, m_row, m_streak, m_cand, m_rel, m_code;
  bit         m_valid, m_held;
  keypad_scan_ctrl_if kif();
  keypad_scan_ctrl #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB)) dut (.sys_clk(clk), .sys_rst(rst), .kp(kif));
  assign rows  = {kif.D, kif.C, kif.B, kif.A};
  assign kif.E = key_on && key_cols[0] && rows[key_row];
  assign kif.F = key_on && key_cols[1] && rows[key_row];
  assign kif.G = key_on && key_cols[2] && rows[key_row];
  initial begin
    clk = 0;
    forever #10 clk = ~clk;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    #1;
  endtask
  task automatic model_step();
    logic [2:0] raw, pat;
    int c;
    raw = key_on && key_row == m_row ? key_cols : 3'b000;
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_ph = 0; m_row = 0; m_streak = 0; m_rel = 0;
      m_held = 0; m_valid = 0; m_code = 0; m_cand = 0;
      return;
    end
    pat = m_s2;
    m_valid = 0;
    if (m_ph == SD - 1) begin
      c = pat == 3'b001 ? 0 : pat == 3'b010 ? 1 : pat == 3'b100 ? 2 : -1;
      if (m_held) begin
        m_rel = pat == 3'b000 ? m_rel + 1 : 0;
        if (m_rel == DB) begin
          m_held = 0; m_rel = 0; m_row = (m_row + 1) % 4;
        end
      end else if (m_streak > 0) begin
        if (c >= 0 && m_row * 3 + c == m_cand) begin
          m_streak++;
          if (m_streak == DB) begin
            m_valid = 1; m_held = 1; m_code = m_cand; m_streak = 0;
          end
        end else begin
          m_streak = 0; m_row = (m_row + 1) % 4;
        end
      end else if (c >= 0) begin
        m_cand = m_row * 3 + c; m_streak = 1;
      end else
        m_row = (m_row + 1) % 4;
    end
    m_ph = (m_ph + 1) % SD;
    m_s2 = m_s1;
    m_s1 = raw;
  endtask
  initial forever begin
    @(posedge clk);
    model_step();
  end
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("rows", rows, 4'b0001 << m_row);
      chk("key_valid", kif.key_valid, m_valid);
      chk("key_held", kif.key_held, m_held);
      chk("key_code", kif.key_code, m_code);
      if (kif.key_valid) begin
        n_valid++;
        last_code = kif.key_code;
      end
      rows_seen |= rows;
    end
  end
  task automatic wait_valid(input string tag, input int limit);
    int v;
    v = n_valid;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (n_valid != v) break;
    end
    chk(tag, n_valid - v, 1);
  endtask
  task automatic release_key(input string tag);
    key_on = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (!kif.key_held) break;
    end
    chk(tag, kif.key_held, 0);
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int v, n;
    key_on = 0; key_row = 0; key_cols = 3'b000; rst = 1;
    tick();
    chk_en = 1;
    tick(); tick();
    rst = 0;
    chk("rst_valid", kif.key_valid, 0);
    chk("rst_held", kif.key_held, 0);
    chk("rst_code", kif.key_code, 0);
    for (int i = 0; i < 20; i++) begin
      chk("scan_row", rows, 4'b0001 << ((i / 4) % 4));
      tick();
    end
    chk("idle_nvalid", n_valid, 0);
    key_row = 1; key_cols = 3'b010; key_on = 1;
    v = n_valid;
    wait_valid("f1_valid", 100);
    chk("f1_code", last_code, 4);
    chk("f1_held", kif.key_held, 1);
    repeat ($urandom_range(10, 40)) tick();
    chk("f1_once", n_valid - v, 1);
    release_key("f1_release");
    chk("f1_resume_c", rows, 4'b0100);
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 40; i++) begin
        if (rows == 4'b1000) break;
        tick();
      end
      chk("g3_rowd", rows, 4'b1000);
      key_row = 3; key_cols = 3'b100; key_on = 0;
      v = n_valid;
      n = $urandom_range(2, 9);
      #1;
      for (int i = 0; i < n; i++) begin
        key_on = ~key_on;
        #3;
      end
      key_on = 1;
      tick();
      chk("g3_bounce_quiet", n_valid - v, 0);
      wait_valid("g3_valid", 200);
      chk("g3_code", last_code, 11);
      repeat ($urandom_range(5, 30)) tick();
      chk("g3_once", n_valid - v, 1);
      release_key("g3_release");
    end
    key_row = 0; key_cols = 3'b101; key_on = 1;
    v = n_valid;
    rows_seen = 0;
    repeat (40) tick();
    chk("multi_nvalid", n_valid - v, 0);
    chk("multi_rotate", rows_seen, 4'hF);
    key_on = 0;
    repeat (4) tick();
    key_row = 2; key_cols = 3'b001; key_on = 1;
    v = n_valid;
    wait_valid("e2_valid", 100);
    chk("e2_code", last_code, 6);
    rows_seen = 0;
    repeat (200) tick();
    chk("e2_frozen", rows_seen, 4'b0100);
    chk("e2_once", n_valid - v, 1);
    release_key("e2_release");
    key_row = 1; key_cols = 3'b001; key_on = 1;
    for (int i = 0; i < 100; i++) begin
      if (m_streak == 2) break;
      tick();
    end
    chk("rc_reach2", m_streak, 2);
    v = n_valid;
    rst = 1;
    key_on = 0;
    tick();
    chk("rc_rows", rows, 4'b0001);
    chk("rc_valid", kif.key_valid, 0);
    chk("rc_held", kif.key_held, 0);
    chk("rc_code", kif.key_code, 0);
    rst = 0;
    repeat (30) tick();
    chk("rc_nvalid", n_valid - v, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
